bcp_cmd_driver: RTL
===================

// Module: bcp_cmd_driver
// PURPOSE
// - Host-side initiator for the BCP accelerator register protocol. Accepts SAT-solver commands
//   (update clause / decision / backtrack) on a valid/ready port and drives the accelerator's
//   axi_reg0..3 inputs. Completes the clear_cpu_req handshake, captures every status write
//   (reg4/reg5) into a response FIFO, and sits between the solver control logic and the accelerator.
// PARAMETERS
// - VARIABLE_ENCODING_LEN  5    bits per variable id
// - CLAUSE_ID_LEN          7    bits per clause id
// - RSP_FIFO_DEPTH         8    response FIFO entries (power of 2, >=2)
// - TIMEOUT_CYCLES         4096 max cycles from issue to terminal status (timeout build only)
// PORTS
// - clk_i          in   1   clock
// - rst_ni         in   1   asynchronous reset, active-low
// - cmd_valid_i    in   1   command valid
// - cmd_ready_o    out  1   command accepted when valid&ready
// - cmd_op_i       in   2   00 NOP, 01 UPDATE_CLAUSE, 10 DECISION, 11 BACKTRACK
// - cmd_clause_id_i in  CLAUSE_ID_LEN      clause to update
// - cmd_lits_i     in   3*(VARIABLE_ENCODING_LEN+1)  lit k at [k*(V+1)+:V+1] = {var_id,polarity}
// - rsp_valid_o    out  1   response valid
// - rsp_ready_i    in   1   response consumed when valid&ready
// - rsp_status_o   out  32  captured reg4 (1 done, 4 conflict, 5 all SAT, 6 implication, 0 timeout)
// - rsp_impl_o     out  VARIABLE_ENCODING_LEN+1  captured reg5 {var_id,assignment}
// - rsp_last_o     out  1   1 = terminal response of the command
// - rsp_overflow_o out  1   sticky: an implication response was dropped
// - busy_o         out  1   command in flight
// - axi_reg0_o..axi_reg3_o  out 32 each  reg0 {clause_id,op} at [2+:C],[1:0]; reg1..3 {var_id,pol} at [1+:V],[0]
// - axi_reg4_i     in   32  accelerator status word
// - axi_reg5_i     in   VARIABLE_ENCODING_LEN+1  accelerator implication
// - clear_cpu_req_i    in 1  accelerator has latched the op
// - write_status_reg_i in 1  accelerator status write strobe/level
// BEHAVIOUR
// - Reset: all outputs 0, all axi_reg*_o 0, FIFO empty, overflow clear, FSM IDLE. A reset
//   mid-command aborts it; op field is 0 immediately.
// - cmd_ready_o = (state==IDLE) && response FIFO empty. This reserves a slot for the terminal response.
// - FSM: IDLE -> ISSUE -> WAIT_ACK -> WAIT_STATUS -> IDLE.
// - IDLE: on handshake with op!=00, load reg0..3 (unused fields 0) at the same edge and go to
//   WAIT_ACK. reg0[1:0]=op is visible the cycle after acceptance.
//   A NOP is accepted and pushes {status 1, last 1} next cycle without touching the accelerator.
// - WAIT_ACK: hold all regs. On clear_cpu_req_i==1, clear reg0[1:0] to 00 next cycle
//   (reg1..3 held), clear last-captured tracker, go to WAIT_STATUS.
// - WAIT_STATUS capture event: write_status_reg_i==1 and (rising edge or {reg4,reg5} differs from last
//   captured). This covers back-to-back implications while the strobe stays high.
//   - reg4==6: push {6,reg5,last 0}; stay. If FIFO occupancy == DEPTH-1 (reserved slot),
//     drop the entry and set rsp_overflow_o.
//   - any other value: push {reg4,reg5,last 1}; go to IDLE.
// - A push in cycle N is visible on rsp_valid_o in N+1. The FIFO is first-word-fall-through; a
//   simultaneous push and pop are both honoured.
// - busy_o = state!=IDLE.
// - rsp_overflow_o is cleared only by reset.
// CONFIGURATION
// - BCP_CMD_DRIVER_TIMEOUT_EN defined: a 32-bit cycle counter starts at acceptance.
//   - Reaching TIMEOUT_CYCLES in WAIT_ACK/WAIT_STATUS forces reg0[1:0]=00 and pushes
//     {status 0, impl 0, last 1} into the reserved slot, then goes to IDLE.
//   - A capture event in the same cycle as the timeout wins.
// - Undefined: no counter; the driver waits indefinitely and never emits status 0.
// TESTING
// - UPDATE_CLAUSE id 5, lits {3,1},{7,0},{12,1} -> reg0=0x15, reg1=0x7, reg2=0xE, reg3=0x19;
//   ack -> reg0[1:0]=0; reg4=1 strobe -> one rsp {1,last 1}.
// - DECISION var 4 pol 1 with accelerator model emitting impl {9,0} then {2,1} on a held strobe,
//   then reg4=5 -> three responses: 6/0x12, 6/0x05, 5 last.
// - rsp_ready_i held 0, DEPTH=4, 4 implications -> 3 stored, 4th dropped with overflow=1;
//   terminal still delivered in the 4th slot.
// - rst_ni asserted in WAIT_STATUS -> all outputs 0 asynchronously; a new command is accepted after release.
// - TIMEOUT_EN, TIMEOUT_CYCLES=16, no clear_cpu_req -> at cycle 16 reg0 op=00 and
//   rsp {0,last 1}; without macro, busy_o stays 1.
// - cmd_valid with FIFO non-empty -> cmd_ready_o=0 until drained; a NOP returns {1,last 1} in 1 cycle.

Source files
------------

// File: rtl/bcp_cmd_driver_if.sv
// rtl/bcp_cmd_driver_if.sv - Command, response and accelerator register bundle for bcp_cmd_driver.
// master = driver side, slave = solver/accelerator environment side.
interface bcp_cmd_driver_if #(
  parameter int VARIABLE_ENCODING_LEN = 5,
  parameter int CLAUSE_ID_LEN         = 7
);
  localparam int L = VARIABLE_ENCODING_LEN + 1;

  logic                     cmd_valid_i;
  logic                     cmd_ready_o;
  logic [1:0]               cmd_op_i;
  logic [CLAUSE_ID_LEN-1:0] cmd_clause_id_i;
  logic [3*L-1:0]           cmd_lits_i;

  logic                     rsp_valid_o;
  logic                     rsp_ready_i;
  logic [31:0]              rsp_status_o;
  logic [L-1:0]             rsp_impl_o;
  logic                     rsp_last_o;
  logic                     rsp_overflow_o;
  logic                     busy_o;

  logic [31:0]              axi_reg0_o;
  logic [31:0]              axi_reg1_o;
  logic [31:0]              axi_reg2_o;
  logic [31:0]              axi_reg3_o;
  logic [31:0]              axi_reg4_i;
  logic [L-1:0]             axi_reg5_i;
  logic                     clear_cpu_req_i;
  logic                     write_status_reg_i;

  modport master (
    input  cmd_valid_i, cmd_op_i, cmd_clause_id_i, cmd_lits_i, rsp_ready_i,
           axi_reg4_i, axi_reg5_i, clear_cpu_req_i, write_status_reg_i,
    output cmd_ready_o, rsp_valid_o, rsp_status_o, rsp_impl_o, rsp_last_o,
           rsp_overflow_o, busy_o, axi_reg0_o, axi_reg1_o, axi_reg2_o, axi_reg3_o
  );

  modport slave (
    output cmd_valid_i, cmd_op_i, cmd_clause_id_i, cmd_lits_i, rsp_ready_i,
           axi_reg4_i, axi_reg5_i, clear_cpu_req_i, write_status_reg_i,
    input  cmd_ready_o, rsp_valid_o, rsp_status_o, rsp_impl_o, rsp_last_o,
           rsp_overflow_o, busy_o, axi_reg0_o, axi_reg1_o, axi_reg2_o, axi_reg3_o
  );
endinterface

// File: rtl/bcp_cmd_driver.sv
// rtl/bcp_cmd_driver.sv - Host-side BCP accelerator command driver with response FIFO.
// Optional issue-to-status watchdog enabled by defining BCP_CMD_DRIVER_TIMEOUT_EN.
module bcp_cmd_driver #(
  parameter int VARIABLE_ENCODING_LEN = 5,
  parameter int CLAUSE_ID_LEN         = 7,
  parameter int RSP_FIFO_DEPTH        = 8,
  parameter int TIMEOUT_CYCLES        = 4096
) (
  input logic              clk_i,
  input logic              rst_ni,
  bcp_cmd_driver_if.master bus
);
  localparam int L  = VARIABLE_ENCODING_LEN + 1;
  localparam int PW = $clog2(RSP_FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0]  OP_NOP  = 2'b00;
  localparam logic [1:0]  OP_UPD  = 2'b01;
  localparam logic [31:0] ST_DONE = 32'd1;
  localparam logic [31:0] ST_IMPL = 32'd6;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_STATUS} state_t;
  state_t state_q, state_d;

  logic [31:0]   reg0_q, reg1_q, reg2_q, reg3_q;
  logic          rdy_en_q;
  logic          wsr_q;
  logic          overflow_q;
  logic [31+L:0] trk_q;

  logic [31:0]   st_mem   [RSP_FIFO_DEPTH];
  logic [L-1:0]  impl_mem [RSP_FIFO_DEPTH];
  logic          last_mem [RSP_FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  logic          fifo_empty, accept, capture, pop, reserved_slot, timeout_hit;
  logic          load, clear_op, trk_clear, trk_load, push, drop;
  logic [31:0]   push_status;
  logic [L-1:0]  push_impl;
  logic          push_last;

  assign fifo_empty    = (count_q == '0);
  assign accept        = rdy_en_q && (state_q == IDLE) && fifo_empty && bus.cmd_valid_i;
  assign pop           = !fifo_empty && bus.rsp_ready_i;
  assign reserved_slot = (count_q == CW'(RSP_FIFO_DEPTH - 1));
  // A held strobe still yields a new capture whenever the status/implication pair changes.
  assign capture       = bus.write_status_reg_i &&
                         (!wsr_q || ({bus.axi_reg4_i, bus.axi_reg5_i} != trk_q));

`ifdef BCP_CMD_DRIVER_TIMEOUT_EN
  logic [31:0] tmo_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_cnt_q <= '0;
    end else if (load) begin
      tmo_cnt_q <= 32'd1;
    end else if ((state_q == WAIT_ACK) || (state_q == WAIT_STATUS)) begin
      tmo_cnt_q <= tmo_cnt_q + 32'd1;
    end
  end

  assign timeout_hit = ((state_q == WAIT_ACK) || (state_q == WAIT_STATUS)) &&
                       (tmo_cnt_q >= 32'(TIMEOUT_CYCLES));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    load        = 1'b0;
    clear_op    = 1'b0;
    trk_clear   = 1'b0;
    trk_load    = 1'b0;
    push        = 1'b0;
    drop        = 1'b0;
    push_status = '0;
    push_impl   = '0;
    push_last   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (bus.cmd_op_i == OP_NOP) begin
            push        = 1'b1;
            push_status = ST_DONE;
            push_last   = 1'b1;
          end else begin
            load    = 1'b1;
            state_d = WAIT_ACK;
          end
        end
      end
      // Issue happens on the acceptance edge; this encoding only recovers to WAIT_ACK.
      ISSUE: state_d = WAIT_ACK;
      WAIT_ACK: begin
        if (timeout_hit) begin
          clear_op  = 1'b1;
          push      = 1'b1;
          push_last = 1'b1;
          state_d   = IDLE;
        end else if (bus.clear_cpu_req_i) begin
          clear_op  = 1'b1;
          trk_clear = 1'b1;
          state_d   = WAIT_STATUS;
        end
      end
      WAIT_STATUS: begin
        if (capture) begin
          trk_load = 1'b1;
          if (bus.axi_reg4_i == ST_IMPL) begin
            // The last slot is held back so the terminal response always fits.
            if (reserved_slot) begin
              drop = 1'b1;
            end else begin
              push        = 1'b1;
              push_status = ST_IMPL;
              push_impl   = bus.axi_reg5_i;
            end
          end else begin
            push        = 1'b1;
            push_status = bus.axi_reg4_i;
            push_impl   = bus.axi_reg5_i;
            push_last   = 1'b1;
            state_d     = IDLE;
          end
        end else if (timeout_hit) begin
          clear_op  = 1'b1;
          push      = 1'b1;
          push_last = 1'b1;
          state_d   = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reg0_q <= '0;
      reg1_q <= '0;
      reg2_q <= '0;
      reg3_q <= '0;
    end else if (load) begin
      if (bus.cmd_op_i == OP_UPD) begin
        reg0_q <= (32'(bus.cmd_clause_id_i) << 2) | 32'(bus.cmd_op_i);
        reg2_q <= 32'(bus.cmd_lits_i[L +: L]);
        reg3_q <= 32'(bus.cmd_lits_i[2*L +: L]);
      end else begin
        reg0_q <= 32'(bus.cmd_op_i);
        reg2_q <= '0;
        reg3_q <= '0;
      end
      reg1_q <= 32'(bus.cmd_lits_i[0 +: L]);
    end else if (clear_op) begin
      reg0_q[1:0] <= 2'b00;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdy_en_q   <= 1'b0;
      wsr_q      <= 1'b0;
      overflow_q <= 1'b0;
      trk_q      <= '0;
    end else begin
      rdy_en_q   <= 1'b1;
      wsr_q      <= bus.write_status_reg_i;
      overflow_q <= overflow_q | drop;
      if (trk_clear) begin
        trk_q <= '0;
      end else if (trk_load) begin
        trk_q <= {bus.axi_reg4_i, bus.axi_reg5_i};
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      st_mem[wr_ptr_q]   <= push_status;
      impl_mem[wr_ptr_q] <= push_impl;
      last_mem[wr_ptr_q] <= push_last;
    end
  end

  assign bus.cmd_ready_o    = rdy_en_q && (state_q == IDLE) && fifo_empty;
  assign bus.busy_o         = (state_q != IDLE);
  assign bus.rsp_valid_o    = !fifo_empty;
  assign bus.rsp_status_o   = fifo_empty ? '0 : st_mem[rd_ptr_q];
  assign bus.rsp_impl_o     = fifo_empty ? '0 : impl_mem[rd_ptr_q];
  assign bus.rsp_last_o     = fifo_empty ? 1'b0 : last_mem[rd_ptr_q];
  assign bus.rsp_overflow_o = overflow_q;
  assign bus.axi_reg0_o     = reg0_q;
  assign bus.axi_reg1_o     = reg1_q;
  assign bus.axi_reg2_o     = reg2_q;
  assign bus.axi_reg3_o     = reg3_q;
endmodule
